// File: rtl/miv_ram_tp_ecc_scrub.sv
// miv_ram_tp_ecc_scrub
// Two-port (one write, one read) SECDED-protected RAM with automatic
// write-back of corrected data after a single-bit error.
//
// Codeword layout (index = Hamming position): bit 0 holds the overall
// parity, bits 1..N hold the Hamming word with check bits at power-of-two
// positions and data filling the remaining positions in ascending order.
//
// Ports
//   CLK, RESETN            clock, asynchronous active-low reset
//   WEN/WADDR/WD/INJ       write port; INJ flips data bit 0 (01) or bits 0,1 (10)
//   REN/RADDR              read request, sampled at the rising edge
//   RD/RD_VALID            read data (corrected when ECC_EN=1), valid one cycle later
//   SB_CORRECT/DB_DETECT   single-corrected / double-detected flags for the current read
//   SCRUB_BUSY             a corrected-data write-back is pending
//   SB_COUNT/DB_COUNT      saturating error counters
//   ERR_ADDR               address of the most recent flagged read
//   CNT_CLR                synchronous clear of the counters and ERR_ADDR
//
// Scrub FSM
//   state    | meaning
//   SCR_IDLE | no write-back pending
//   SCR_PEND | corrected word held, waiting for a cycle with WEN=0

module miv_ram_tp_ecc_scrub #(
  parameter int DATA_WIDTH = 21,
  parameter int ADDR_WIDTH = 7,
  parameter int ECC_EN     = 1,
  parameter int SCRUB_EN   = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  WEN,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic [1:0]            INJ,
  input  logic                  REN,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  RD_VALID,
  output logic                  SB_CORRECT,
  output logic                  DB_DETECT,
  output logic                  SCRUB_BUSY,
  output logic [CNT_WIDTH-1:0]  SB_COUNT,
  output logic [CNT_WIDTH-1:0]  DB_COUNT,
  output logic [ADDR_WIDTH-1:0] ERR_ADDR,
  input  logic                  CNT_CLR
);

  function automatic int calc_r(input int dw);
    int r;
    r = 1;
    for (int i = 0; i < 8; i++)
      if ((1 << r) < dw + r + 1) r = r + 1;
    return r;
  endfunction

  localparam int R     = calc_r(DATA_WIDTH);
  localparam int N     = DATA_WIDTH + R;
  localparam int CW    = N + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit ECC_ON   = (ECC_EN != 0);
  localparam bit SCRUB_ON = (SCRUB_EN != 0);
  // data bits 0 and 1 always land at Hamming positions 3 and 5
  localparam int POS_D0 = 3;
  localparam int POS_D1 = 5;

  function automatic logic [CW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k = k + 1;
      end
    for (int i = 0; i < R; i++)
      for (int p = 1; p <= N; p++)
        if ((((p >> i) & 1) == 1) && (p != (1 << i)))
          c[1 << i] = c[1 << i] ^ c[p];
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW-1:0] c);
    logic [DATA_WIDTH-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k = k + 1;
      end
    return d;
  endfunction

  typedef enum logic {SCR_IDLE, SCR_PEND} scr_state_t;

  logic [CW-1:0]         mem [0:DEPTH-1];
  logic [CW-1:0]         rd_cw;
  logic                  rd_valid;
  logic                  rd_coll;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic [R-1:0]          syn;
  logic                  par_err;
  logic                  syn_oob;
  logic                  single_err;
  logic                  double_err;
  logic [CW-1:0]         fix_cw;
  logic [DATA_WIDTH-1:0] raw_data;
  logic [DATA_WIDTH-1:0] cor_data;
  logic                  sb_flag;
  logic                  db_flag;

  scr_state_t            scr_state, scr_next;
  logic                  scrub_load;
  logic                  scrub_issue;
  logic [ADDR_WIDTH-1:0] scrub_addr;
  logic [DATA_WIDTH-1:0] scrub_data;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [CW-1:0]         mem_wcw;

  // write port: user writes win, otherwise the pending scrub drains
  always_comb begin
    mem_we    = RESETN && (WEN || scrub_issue);
    mem_waddr = WEN ? WADDR : scrub_addr;
    mem_wcw   = encode(WEN ? WD : scrub_data);
    if (WEN) begin
      if (INJ == 2'b01) begin
        mem_wcw[POS_D0] = ~mem_wcw[POS_D0];
      end else if (INJ == 2'b10) begin
        mem_wcw[POS_D0] = ~mem_wcw[POS_D0];
        mem_wcw[POS_D1] = ~mem_wcw[POS_D1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wcw;
  end

  // read register; the array read sees the pre-edge contents, so a
  // same-address write in the same cycle returns the old word
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rd_cw    <= '0;
      rd_valid <= 1'b0;
      rd_coll  <= 1'b0;
      rd_addr  <= '0;
    end else begin
      rd_valid <= REN;
      if (REN) begin
        rd_cw   <= mem[RADDR];
        rd_addr <= RADDR;
        rd_coll <= WEN && (WADDR == RADDR);
      end
    end
  end

  always_comb begin
    syn     = '0;
    par_err = ^rd_cw;
    for (int p = 1; p <= N; p++)
      if (rd_cw[p]) syn = syn ^ p[R-1:0];
    syn_oob    = (int'(syn) > N);
    single_err = par_err && !syn_oob;
    double_err = (!par_err && (syn != '0)) || (par_err && syn_oob);
    fix_cw     = rd_cw;
    if (single_err)
      for (int p = 0; p <= N; p++)
        if (p == int'(syn)) fix_cw[p] = ~rd_cw[p];
    raw_data = extract(rd_cw);
    cor_data = extract(fix_cw);
  end

  assign sb_flag    = ECC_ON && rd_valid && !rd_coll && single_err;
  assign db_flag    = ECC_ON && rd_valid && !rd_coll && double_err;
  assign RD         = ECC_ON ? cor_data : raw_data;
  assign RD_VALID   = rd_valid;
  assign SB_CORRECT = sb_flag;
  assign DB_DETECT  = db_flag;
  assign SCRUB_BUSY = (scr_state == SCR_PEND);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) scr_state <= SCR_IDLE;
    else         scr_state <= scr_next;
  end

  // a write to the erroneous word at the load edge already supersedes it,
  // so the entry is not loaded in that case
  always_comb begin
    scr_next    = scr_state;
    scrub_load  = 1'b0;
    scrub_issue = 1'b0;
    case (scr_state)
      SCR_IDLE: begin
        if (SCRUB_ON && sb_flag && !(WEN && (WADDR == rd_addr))) begin
          scrub_load = 1'b1;
          scr_next   = SCR_PEND;
        end
      end
      SCR_PEND: begin
        if (!WEN) begin
          scrub_issue = 1'b1;
          scr_next    = SCR_IDLE;
        end else if (WADDR == scrub_addr) begin
          scr_next = SCR_IDLE;
        end
      end
      default: scr_next = SCR_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      scrub_addr <= '0;
      scrub_data <= '0;
    end else if (scrub_load) begin
      scrub_addr <= rd_addr;
      scrub_data <= cor_data;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      SB_COUNT <= '0;
      DB_COUNT <= '0;
      ERR_ADDR <= '0;
    end else if (CNT_CLR) begin
      SB_COUNT <= '0;
      DB_COUNT <= '0;
      ERR_ADDR <= '0;
    end else begin
      if (sb_flag && (SB_COUNT != '1)) SB_COUNT <= SB_COUNT + 1'b1;
      if (db_flag && (DB_COUNT != '1)) DB_COUNT <= DB_COUNT + 1'b1;
      if (sb_flag || db_flag) ERR_ADDR <= rd_addr;
    end
  end

endmodule

// File: tb/tb_miv_ram_tp_ecc_scrub.sv
`timescale 1ns/1ps
module tb_miv_ram_tp_ecc_scrub;
  localparam int DW  = 21;
  localparam int AW  = 7;
  localparam int CNW = 8;
  localparam int SAT = (1 << CNW) - 1;

  logic           CLK = 1'b0;
  logic           RESETN = 1'b0;
  logic           WEN = 1'b0;
  logic [AW-1:0]  WADDR = '0;
  logic [DW-1:0]  WD = '0;
  logic [1:0]     INJ = '0;
  logic           REN = 1'b0;
  logic [AW-1:0]  RADDR = '0;
  logic           CNT_CLR = 1'b0;
  logic [DW-1:0]  RD;
  logic           RD_VALID, SB_CORRECT, DB_DETECT, SCRUB_BUSY;
  logic [CNW-1:0] SB_COUNT, DB_COUNT;
  logic [AW-1:0]  ERR_ADDR;

  miv_ram_tp_ecc_scrub #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ECC_EN(1), .SCRUB_EN(1), .CNT_WIDTH(CNW)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .WEN(WEN), .WADDR(WADDR), .WD(WD), .INJ(INJ),
    .REN(REN), .RADDR(RADDR), .RD(RD), .RD_VALID(RD_VALID),
    .SB_CORRECT(SB_CORRECT), .DB_DETECT(DB_DETECT), .SCRUB_BUSY(SCRUB_BUSY),
    .SB_COUNT(SB_COUNT), .DB_COUNT(DB_COUNT), .ERR_ADDR(ERR_ADDR), .CNT_CLR(CNT_CLR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference: each word is its user data plus an error class
  // (0 clean, 1 single flip, 2 double flip of data bits 0 and 1)
  logic [DW-1:0] m_dat [0:(1<<AW)-1];
  int            m_err [0:(1<<AW)-1];
  bit            m_pend;
  logic [AW-1:0] m_pend_addr;
  int            m_sb_cnt, m_db_cnt;
  logic [AW-1:0] m_err_addr;
  bit            p_sb, p_db;
  logic [AW-1:0] p_addr;
  bit            e_valid, e_sb, e_db;
  logic [DW-1:0] e_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_pend_addr = '0;
    m_sb_cnt = 0; m_db_cnt = 0; m_err_addr = '0;
    p_sb = 0; p_db = 0; p_addr = '0;
    e_valid = 0; e_sb = 0; e_db = 0;
  endtask

  task automatic check_all();
    chk("rd_valid", RD_VALID, e_valid);
    chk("sb_correct", SB_CORRECT, e_sb);
    chk("db_detect", DB_DETECT, e_db);
    if (e_valid) chk("rd", RD, e_rd);
    chk("scrub_busy", SCRUB_BUSY, m_pend);
    chk("sb_count", SB_COUNT, m_sb_cnt);
    chk("db_count", DB_COUNT, m_db_cnt);
    chk("err_addr", ERR_ADDR, m_err_addr);
  endtask

  task automatic cyc(input bit wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [1:0] inj, input bit ren, input logic [AW-1:0] ra,
                     input bit clr);
    bit coll, n_sb, n_db;
    int et;
    WEN = wen; WADDR = wa; WD = wd; INJ = inj;
    REN = ren; RADDR = ra; CNT_CLR = clr;
    @(posedge CLK);
    coll = wen && (wa == ra);
    n_sb = 0; n_db = 0;
    if (ren) begin
      et   = m_err[ra];
      e_rd = (et == 2) ? (m_dat[ra] ^ 21'h3) : m_dat[ra];
      n_sb = !coll && (et == 1);
      n_db = !coll && (et == 2);
    end
    if (clr) begin
      m_sb_cnt = 0; m_db_cnt = 0; m_err_addr = '0;
    end else begin
      if (p_sb && m_sb_cnt < SAT) m_sb_cnt++;
      if (p_db && m_db_cnt < SAT) m_db_cnt++;
      if (p_sb || p_db) m_err_addr = p_addr;
    end
    if (m_pend) begin
      if (!wen) begin
        m_err[m_pend_addr] = 0;
        m_pend = 0;
      end else if (wa == m_pend_addr) begin
        m_pend = 0;
      end
    end else if (p_sb && !(wen && wa == p_addr)) begin
      m_pend = 1;
      m_pend_addr = p_addr;
    end
    if (wen) begin
      m_dat[wa] = wd;
      m_err[wa] = (inj == 2'b01) ? 1 : (inj == 2'b10) ? 2 : 0;
    end
    e_valid = ren; e_sb = n_sb; e_db = n_db;
    p_sb = n_sb; p_db = n_db;
    if (ren) p_addr = ra;
    #1;
    check_all();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] inj);
    cyc(1, a, d, inj, 0, '0, 0);
  endtask

  task automatic rdq(input logic [AW-1:0] a);
    cyc(0, '0, '0, 2'b00, 1, a, 0);
  endtask

  task automatic idle();
    cyc(0, '0, '0, 2'b00, 0, '0, 0);
  endtask

  initial begin
    logic [DW-1:0] rd_d;
    logic [AW-1:0] rnd_wa, rnd_ra;
    logic [1:0]    rnd_inj;
    model_reset();
    for (int i = 0; i < (1 << AW); i++) begin
      m_dat[i] = '0;
      m_err[i] = 0;
    end

    RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rd", RD, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    chk("rst_sb", SB_CORRECT, 0);
    chk("rst_db", DB_DETECT, 0);
    chk("rst_busy", SCRUB_BUSY, 0);
    chk("rst_sb_count", SB_COUNT, 0);
    chk("rst_db_count", DB_COUNT, 0);
    chk("rst_err_addr", ERR_ADDR, 0);
    @(negedge CLK);
    RESETN = 1'b1;

    // clean path
    wr(7'h03, 21'h15A5A5, 2'b00);
    rdq(7'h03);
    chk("tp_clean_rd", RD, 21'h15A5A5);
    chk("tp_clean_flags", {RD_VALID, SB_CORRECT, DB_DETECT}, 3'b100);

    // single error, scrub with the write port free
    wr(7'h10, 21'h000000, 2'b01);
    rdq(7'h10);
    chk("tp_sb_rd", RD, 0);
    chk("tp_sb_flag", SB_CORRECT, 1);
    idle();
    chk("tp_sb_count", SB_COUNT, 1);
    chk("tp_sb_err_addr", ERR_ADDR, 7'h10);
    chk("tp_sb_busy", SCRUB_BUSY, 1);
    idle();
    chk("tp_sb_busy_fall", SCRUB_BUSY, 0);
    rdq(7'h10);
    chk("tp_sb_reread", SB_CORRECT, 0);

    // double error
    wr(7'h7F, 21'h1FFFFF, 2'b10);
    rdq(7'h7F);
    chk("tp_db_rd", RD, 21'h1FFFFC);
    chk("tp_db_flags", {SB_CORRECT, DB_DETECT}, 2'b01);
    idle();
    chk("tp_db_count", DB_COUNT, 1);
    chk("tp_db_noscrub", SCRUB_BUSY, 0);

    // scrub held off by three user writes
    wr(7'h20, 21'h054321, 2'b01);
    rdq(7'h20);
    idle();
    wr(7'h21, 21'h000001, 2'b00);
    wr(7'h22, 21'h000002, 2'b00);
    wr(7'h23, 21'h000003, 2'b00);
    chk("tp_cont_busy", SCRUB_BUSY, 1);
    idle();
    chk("tp_cont_done", SCRUB_BUSY, 0);
    rdq(7'h20);
    chk("tp_cont_clean", SB_CORRECT, 0);

    // scrub cancelled by a user write to the pending address
    wr(7'h20, 21'h054321, 2'b01);
    rdq(7'h20);
    idle();
    wr(7'h20, 21'h0ABCDE, 2'b00);
    chk("tp_cancel_busy", SCRUB_BUSY, 0);
    rdq(7'h20);
    chk("tp_cancel_rd", RD, 21'h0ABCDE);
    chk("tp_cancel_clean", SB_CORRECT, 0);

    // read/write collision
    wr(7'h05, 21'h0F0F0F, 2'b01);
    cyc(1, 7'h05, 21'h111111, 2'b00, 1, 7'h05, 0);
    chk("tp_coll_rd", RD, 21'h0F0F0F);
    chk("tp_coll_sb", SB_CORRECT, 0);
    idle();
    chk("tp_coll_noscrub", SCRUB_BUSY, 0);
    rdq(7'h05);
    chk("tp_coll_new", RD, 21'h111111);

    // saturation: the scrub stays blocked because WEN never drops
    wr(7'h30, 21'h13579B, 2'b01);
    for (int i = 0; i < 260; i++) begin
      rd_d = DW'($urandom);
      cyc(1, 7'h31, rd_d, 2'b00, 1, 7'h30, 0);
    end
    cyc(1, 7'h31, 21'h0, 2'b00, 0, '0, 0);
    chk("tp_sat", SB_COUNT, 8'hFF);
    cyc(1, 7'h31, 21'h0, 2'b00, 0, '0, 1);
    chk("tp_clr_sb", SB_COUNT, 0);
    chk("tp_clr_db", DB_COUNT, 0);
    chk("tp_pend_before_rst", SCRUB_BUSY, 1);

    // reset with a scrub pending
    WEN = 1'b0; REN = 1'b0; CNT_CLR = 1'b0;
    RESETN = 1'b0;
    #1;
    model_reset();
    chk("tp_rst_busy", SCRUB_BUSY, 0);
    chk("tp_rst_valid", RD_VALID, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETN = 1'b1;
    rdq(7'h30);
    chk("tp_rst_unchanged", SB_CORRECT, 1);
    chk("tp_rst_data", RD, 21'h13579B);
    idle();
    idle();

    // randomized traffic over a small address pool
    for (int i = 0; i < 8; i++) begin
      rd_d = DW'($urandom);
      wr(AW'(7'h40 + i), rd_d, 2'(i % 3));
    end
    for (int i = 0; i < 500; i++) begin
      rd_d    = DW'($urandom);
      rnd_wa  = AW'(7'h40 + $urandom_range(0, 7));
      rnd_ra  = AW'(7'h40 + $urandom_range(0, 7));
      rnd_inj = 2'($urandom_range(0, 3));
      cyc(bit'($urandom_range(0, 1)), rnd_wa, rd_d, rnd_inj,
          bit'($urandom_range(0, 1)), rnd_ra, ($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
